vbw_add_sched: RTL



---
 rtl/vbw_add_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vbw_add_sched.sv
// vbw_add_sched / vbw_cla_kill: round-robin burst scheduler around a lane-killable 64-bit CLA (rev 1.0)
`default_nettype none

module vbw_cla_kill (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        ci,
  input  logic [1:0]  mode,
  output logic [63:0] sum,
  output logic        co
);
  logic [7:0] grp_g, grp_p, kill;
  logic [7:0] cin, cout;

  // A killed byte boundary starts a new lane: carry into that byte is forced to 0.
  always_comb begin
    kill = '0;
    for (int k = 1; k < 8; k++) begin
      case (mode)
        2'b01:   kill[k] = (k == 4);
        2'b10:   kill[k] = (k % 2 == 0);
        2'b11:   kill[k] = 1'b1;
        default: kill[k] = 1'b0;
      endcase
    end
  end

  always_comb begin
    cin  = '0;
    cout = '0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0)
        cin[k] = ci;
      else
        cin[k] = kill[k] ? 1'b0 : cout[k-1];
      cout[k] = grp_g[k] | (grp_p[k] & cin[k]);
    end
  end

  assign co = (mode == 2'b00) ? cout[7] : 1'b0;

  for (genvar k = 0; k < 8; k++) begin : g_byte
    logic [7:0] bg, bp, bs;
    logic       lg, lp, c;
    assign bg = a[8*k +: 8] & b[8*k +: 8];
    assign bp = a[8*k +: 8] ^ b[8*k +: 8];

    always_comb begin
      lg = 1'b0;
      lp = 1'b1;
      for (int i = 0; i < 8; i++) begin
        lg = bg[i] | (bp[i] & lg);
        lp = lp & bp[i];
      end
    end

    always_comb begin
      bs = '0;
      c  = cin[k];
      for (int i = 0; i < 8; i++) begin
        bs[i] = bp[i] ^ c;
        c     = bg[i] | (bp[i] & c);
      end
    end

    assign grp_g[k]      = lg;
    assign grp_p[k]      = lp;
    assign sum[8*k +: 8] = bs;
  end
endmodule

module vbw_add_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [64*N_REQ-1:0]   req_a,
  input  logic [64*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_ci,
  input  logic [2*N_REQ-1:0]    req_mode,
  input  logic [N_REQ-1:0]      req_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_sum,
  output logic                  out_co,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_last,
  output logic [31:0]           op_count
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] rr_ptr, lock_id, win_idle, grant_id, idx;
  logic            win_found, grant_ok, accept, xfer, carry_r;
  logic            eff_ci, g_last, add_co;
  logic [1:0]      g_mode;
  logic [63:0]     add_sum;

  logic [63:0] a_arr [N_REQ];
  logic [63:0] b_arr [N_REQ];
  logic [1:0]  m_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[64*i +: 64];
    assign b_arr[i] = req_b[64*i +: 64];
    assign m_arr[i] = req_mode[2*i +: 2];
  end

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    if (int'(p) >= N_REQ - 1)
      return '0;
    else
      return p + ID_W'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idle  = '0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = ID_W'((int'(rr_ptr) + off) % N_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idle  = idx;
      end
    end
  end

  always_comb begin
    accept    = !out_valid || out_ready;
    grant_id  = (state == LOCKED) ? lock_id : win_idle;
    grant_ok  = (state == LOCKED) ? req_valid[lock_id] : win_found;
    xfer      = grant_ok && accept;
    req_ready = '0;
    if (grant_ok)
      req_ready[grant_id] = accept;
    g_mode = m_arr[grant_id];
    g_last = req_last[grant_id];
    eff_ci = (g_mode == 2'b00) && ((state == LOCKED) ? carry_r : req_ci[grant_id]);
  end

  always_comb begin
    state_nx = state;
    if (xfer) begin
      if (state == IDLE && !g_last)
        state_nx = LOCKED;
      else if (state == LOCKED && g_last)
        state_nx = IDLE;
    end
  end

  vbw_cla_kill u_cla (
    .a    (a_arr[grant_id]),
    .b    (b_arr[grant_id]),
    .ci   (eff_ci),
    .mode (g_mode),
    .sum  (add_sum),
    .co   (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lock_id   <= '0;
      carry_r   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_co    <= 1'b0;
      out_id    <= '0;
      out_last  <= 1'b0;
      op_count  <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        carry_r   <= add_co;
        out_valid <= 1'b1;
        out_sum   <= add_sum;
        out_co    <= add_co;
        out_id    <= grant_id;
        out_last  <= g_last;
        op_count  <= op_count + 32'd1;
        if (state == IDLE && !g_last)
          lock_id <= grant_id;
        if (g_last)
          rr_ptr <= next_ptr(grant_id);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire
